// File: rtl/bip_pkg.sv
// bip_pkg: shared types for the multicycle instruction decoder.
//   opcode_t - 5-bit opcode map of the instruction set
//   alu_op_t - ALU operation select
//   sel_a_t  - accumulator source select
//   state_t  - control FSM states
// Helper functions classify opcodes for the decoder.
package bip_pkg;

   localparam int OPC_BITS = 5;

   typedef enum logic [4:0] {
      OP_HLT  = 5'd0,  OP_STO  = 5'd1,  OP_LD   = 5'd2,  OP_LDI  = 5'd3,
      OP_ADD  = 5'd4,  OP_ADDI = 5'd5,  OP_SUB  = 5'd6,  OP_SUBI = 5'd7,
      OP_BEQ  = 5'd8,  OP_BNE  = 5'd9,  OP_BGT  = 5'd10, OP_BGE  = 5'd11,
      OP_BLT  = 5'd12, OP_BLE  = 5'd13, OP_JMP  = 5'd14, OP_AND  = 5'd15,
      OP_ANDI = 5'd16, OP_OR   = 5'd17, OP_ORI  = 5'd18, OP_XOR  = 5'd19,
      OP_XORI = 5'd20, OP_NOT  = 5'd21, OP_SLL  = 5'd22, OP_SRL  = 5'd23
   } opcode_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR  = 3'd3,
      ALU_XOR = 3'd4, ALU_NOT = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      SELA_MEM = 2'b00, SELA_IMM = 2'b01, SELA_ALU = 2'b10
   } sel_a_t;

   typedef enum logic [2:0] {
      ST_RESET, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_HALT
   } state_t;

   function automatic alu_op_t alu_op_of(opcode_t op);
      case (op)
         OP_SUB, OP_SUBI: return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         OP_XOR, OP_XORI: return ALU_XOR;
         OP_NOT:          return ALU_NOT;
         OP_SLL:          return ALU_SLL;
         OP_SRL:          return ALU_SRL;
         default:         return ALU_ADD;
      endcase
   endfunction

   function automatic logic is_alu_op(opcode_t op);
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_AND, OP_ANDI, OP_OR, OP_ORI,
         OP_XOR, OP_XORI, OP_NOT, OP_SLL, OP_SRL: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(opcode_t op);
      case (op)
         OP_STO, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
         default:                                             return 1'b0;
      endcase
   endfunction

   // ALU B operand comes from the immediate field only for the *I forms.
   function automatic logic is_imm_b(opcode_t op);
      case (op)
         OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   function automatic logic is_branch_op(opcode_t op);
      return (op >= OP_BEQ) && (op <= OP_JMP);
   endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch evaluation.
//   i_opcode - opcode field (5 bits)
//   i_z, i_n - zero / negative flags
//   o_taken  - branch taken; always 0 for non-branch opcodes
module branch_cond
   import bip_pkg::*;
(
   input  logic [4:0] i_opcode,
   input  logic       i_z,
   input  logic       i_n,
   output logic       o_taken
);

   opcode_t w_op;
   assign w_op = opcode_t'(i_opcode);

   always_comb begin
      o_taken = 1'b0;
      case (w_op)
         OP_BEQ:  o_taken = i_z;
         OP_BNE:  o_taken = ~i_z;
         OP_BGT:  o_taken = ~i_z & ~i_n;
         OP_BGE:  o_taken = ~i_n;
         OP_BLT:  o_taken = i_n;
         OP_BLE:  o_taken = i_z | i_n;
         OP_JMP:  o_taken = 1'b1;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: control FSM for a multicycle accumulator CPU.
//   clock_in, reset_in (async, active-low)
//   opcode_in            - opcode field of the instruction register
//   status_Z_in/_N_in    - flags, used only while executing
//   mem_ready_in         - data memory access complete
//   *_wr_out, *_rd_out, branch_out, sel_A_out, sel_B_out, alu_op_out
//                        - datapath controls
//   *_reset_out          - register clears, high in the RESET state
//   halted_out           - HALT state, illegal_out - unmapped opcode executed
// All outputs decode the state register combinationally, so pulling
// reset_in low drops every strobe without waiting for a clock edge.
module multicycle_decoder
   import bip_pkg::*;
#(
   parameter int OPCODE_WIDTH = 5,
   parameter int ALU_OP_WIDTH = 3
)(
   input  logic                    clock_in,
   input  logic                    reset_in,
   input  logic [OPCODE_WIDTH-1:0] opcode_in,
   input  logic                    status_Z_in,
   input  logic                    status_N_in,
   input  logic                    mem_ready_in,
   output logic                    branch_out,
   output logic                    sel_B_out,
   output logic                    data_memory_wr_out,
   output logic                    data_memory_rd_out,
   output logic                    acc_wr_out,
   output logic                    pc_wr_out,
   output logic                    status_wr_out,
   output logic                    ir_wr_out,
   output logic [1:0]              sel_A_out,
   output logic [ALU_OP_WIDTH-1:0] alu_op_out,
   output logic                    acc_reset_out,
   output logic                    pc_reset_out,
   output logic                    status_reset_out,
   output logic                    ir_reset_out,
   output logic                    halted_out,
   output logic                    illegal_out
);

   state_t     r_state;
   state_t     w_next_state;
   logic [31:0] w_opc_ext;
   opcode_t    w_opc;
   logic       w_legal;
   logic       w_taken;
   alu_op_t    w_alu;
   sel_a_t     w_sel_a;

   // Any opcode value beyond the last mapped one (including set bits above
   // the 5-bit field on a wider opcode port) is unmapped.
   assign w_opc_ext = 32'(opcode_in);
   assign w_legal   = (w_opc_ext <= 32'(OP_SRL));
   assign w_opc     = opcode_t'(w_opc_ext[OPC_BITS-1:0]);

   branch_cond u_branch_cond (
      .i_opcode (w_opc_ext[OPC_BITS-1:0]),
      .i_z      (status_Z_in),
      .i_n      (status_N_in),
      .o_taken  (w_taken)
   );

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) r_state <= ST_RESET;
      else           r_state <= w_next_state;
   end

   always_comb begin
      w_next_state       = r_state;
      branch_out         = 1'b0;
      sel_B_out          = 1'b0;
      data_memory_wr_out = 1'b0;
      data_memory_rd_out = 1'b0;
      acc_wr_out         = 1'b0;
      pc_wr_out          = 1'b0;
      status_wr_out      = 1'b0;
      ir_wr_out          = 1'b0;
      w_sel_a            = SELA_MEM;
      w_alu              = ALU_ADD;
      acc_reset_out      = 1'b0;
      pc_reset_out       = 1'b0;
      status_reset_out   = 1'b0;
      ir_reset_out       = 1'b0;
      halted_out         = 1'b0;
      illegal_out        = 1'b0;

      case (r_state)
         ST_RESET: begin
            acc_reset_out    = 1'b1;
            pc_reset_out     = 1'b1;
            status_reset_out = 1'b1;
            ir_reset_out     = 1'b1;
            w_next_state     = ST_FETCH;
         end
         ST_FETCH: begin
            ir_wr_out    = 1'b1;
            w_next_state = ST_DECODE;
         end
         ST_DECODE: begin
            w_next_state = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            if (!w_legal) begin
               illegal_out  = 1'b1;
               pc_wr_out    = 1'b1;
               w_next_state = ST_FETCH;
            end else begin
               w_alu     = alu_op_of(w_opc);
               sel_B_out = is_imm_b(w_opc);
               if (w_opc == OP_LDI)        w_sel_a = SELA_IMM;
               else if (is_alu_op(w_opc))  w_sel_a = SELA_ALU;

               if (w_opc == OP_HLT) begin
                  w_next_state = ST_HALT;
               end else if (is_mem_op(w_opc)) begin
                  // Strobe stays up through the ready cycle; state holds
                  // here until the memory reports completion.
                  data_memory_wr_out = (w_opc == OP_STO);
                  data_memory_rd_out = (w_opc != OP_STO);
                  if (mem_ready_in) begin
                     pc_wr_out     = 1'b1;
                     acc_wr_out    = (w_opc != OP_STO);
                     status_wr_out = is_alu_op(w_opc);
                     w_next_state  = ST_FETCH;
                  end
               end else if (is_branch_op(w_opc)) begin
                  pc_wr_out    = 1'b1;
                  branch_out   = w_taken;
                  w_next_state = ST_FETCH;
               end else begin
                  acc_wr_out    = 1'b1;
                  pc_wr_out     = 1'b1;
                  status_wr_out = is_alu_op(w_opc);
                  w_next_state  = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            halted_out = 1'b1;
         end
         default: begin
            w_next_state = ST_RESET;
         end
      endcase
   end

   assign sel_A_out  = w_sel_a;
   assign alu_op_out = ALU_OP_WIDTH'(w_alu);

endmodule

// File: doc/multicycle_decoder.md
MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 The block SHALL have parameter OPCODE_WIDTH, default 5, giving the opcode field width.
REQ-002 The block SHALL have parameter ALU_OP_WIDTH, default 3, giving the ALU operation select width.
REQ-003 The block SHALL have port clock_in, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port opcode_in, input, OPCODE_WIDTH bits: the opcode field of the instruction register.
REQ-006 The block SHALL have ports status_Z_in and status_N_in, inputs, 1 bit each: zero and negative flags.
REQ-007 The block SHALL have port mem_ready_in, input, 1 bit: data memory has completed the current access.
REQ-008 The block SHALL have ports branch_out, sel_B_out, data_memory_wr_out, data_memory_rd_out, acc_wr_out, pc_wr_out, status_wr_out and ir_wr_out, outputs, 1 bit each: datapath controls.
REQ-009 The block SHALL have port sel_A_out, output, 2 bits: accumulator source (00 memory, 01 immediate, 10 ALU).
REQ-010 The block SHALL have port alu_op_out, output, ALU_OP_WIDTH bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLL, 111 SRL.
REQ-011 The block SHALL have ports acc_reset_out, pc_reset_out, status_reset_out and ir_reset_out, outputs, 1 bit each: register clears.
REQ-012 The block SHALL have ports halted_out and illegal_out, outputs, 1 bit each.

Function
REQ-013 The FSM SHALL have states RESET, FETCH, DECODE, EXECUTE and HALT; outputs are Moore, except the EXECUTE controls, which also depend on the opcode, the flags and mem_ready_in.
REQ-014 Transitions: RESET->FETCH->DECODE->EXECUTE, each taking 1 cycle.
REQ-015 EXECUTE SHALL go to FETCH on completion, to HALT on opcode HLT, and SHALL otherwise hold.
REQ-016 FETCH SHALL assert ir_wr_out=1; all other write strobes SHALL be 0 in FETCH and DECODE.
REQ-017 The opcode map SHALL be: 00000 HLT, 00001 STO, 00010 LD, 00011 LDI, 00100 ADD, 00101 ADDI, 00110 SUB, 00111 SUBI.
REQ-018 Opcode map, continued: 01000 BEQ, 01001 BNE, 01010 BGT, 01011 BGE, 01100 BLT, 01101 BLE, 01110 JMP.
REQ-019 Opcode map, continued: 01111 AND, 10000 ANDI, 10001 OR, 10010 ORI, 10011 XOR, 10100 XORI, 10101 NOT, 10110 SLL, 10111 SRL.
REQ-020 Immediate and register-only ops (LDI, *I, NOT, SLL, SRL) SHALL complete in 1 EXECUTE cycle: acc_wr_out=1, pc_wr_out=1, sel_B_out=1 for *I, sel_A_out=01 for LDI and 10 otherwise, and status_wr_out=1 for every ALU op.
REQ-021 Memory ops (STO, LD, ADD, SUB, AND, OR, XOR) SHALL hold data_memory_wr_out (STO) or data_memory_rd_out (others) high in EXECUTE until the cycle in which mem_ready_in=1.
REQ-022 In that mem_ready_in=1 cycle only, memory ops SHALL assert pc_wr_out=1, and acc_wr_out=1 for every memory op except STO.
REQ-023 Branches SHALL complete in 1 EXECUTE cycle with pc_wr_out=1, and branch_out=1 iff: BEQ Z; BNE !Z; BGT !Z&!N; BGE !N; BLT N; BLE Z|N; JMP always.
REQ-024 An unmapped opcode SHALL execute as a NOP (pc_wr_out=1 only) and pulse illegal_out=1 for exactly that EXECUTE cycle.
REQ-025 HLT SHALL give pc_wr_out=0 and enter HALT, where all strobes are 0 and halted_out=1 until reset.
REQ-026 The flags SHALL be sampled only in EXECUTE; flag changes in other states SHALL have no effect.
REQ-027 mem_ready_in SHALL be ignored outside memory-op EXECUTE cycles.

Reset
REQ-028 While reset_in=0, the state SHALL be RESET, all four *_reset_out SHALL be 1, and every other output SHALL be 0 (sel_A_out=00, alu_op_out=000).
REQ-029 *_reset_out SHALL stay 1 in the RESET state for exactly 1 cycle after reset_in deasserts, then 0.
REQ-030 Reset asserted mid-operation (including a memory stall) SHALL abort immediately, with data_memory_rd_out and data_memory_wr_out dropping asynchronously.

Structure
REQ-031 A shared package bip_pkg SHALL hold the opcode enum, the ALU op enum, the sel_A encoding and the state enum.
REQ-032 Branch evaluation SHALL be one sub-module, branch_cond, combinational, taking opcode, Z and N and producing taken.

Verification
REQ-033 Reset release -> exactly 1 cycle with *_reset_out=1, then ir_wr_out=1 in the next (FETCH) cycle.
REQ-034 ADDI -> 3-cycle instruction; in EXECUTE: acc_wr_out=1, status_wr_out=1, sel_A_out=10, sel_B_out=1, alu_op_out=000.
REQ-035 LD with mem_ready_in low for 3 cycles -> data_memory_rd_out=1 for 4 cycles, with acc_wr_out and pc_wr_out only in the 4th.
REQ-036 BGT/BGE/BLT/BLE across all four Z,N combinations -> branch_out matches the REQ-023 table, and Z toggling during DECODE has no effect.
REQ-037 Opcode 11111 -> illegal_out pulses for 1 cycle with pc_wr_out=1; HLT -> halted_out=1 held, with no strobes for 10+ cycles.
REQ-038 reset_in=0 during a STO stall -> data_memory_wr_out=0 immediately, with *_reset_out=1.
